// File: rtl/async_fifo_wptr_full.sv
// Write-side pointer, Gray launch register and full/level status
// for an async FIFO; everything here is in the write clock domain.
module async_fifo_wptr_full #(
    parameter int ADDR_WIDTH = 4,
    parameter int AF_SLACK   = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH:0]   i_rq2_rptr,
    output logic                  o_wr_accept,
    output logic [ADDR_WIDTH-1:0] o_waddr,
    output logic [ADDR_WIDTH:0]   o_wptr,
    output logic                  o_wfull,
    output logic                  o_walmost_full,
    output logic [ADDR_WIDTH:0]   o_wlevel,
    output logic                  o_overflow
);
    localparam int A     = ADDR_WIDTH;
    localparam int DEPTH = 2 ** A;
    localparam logic [A:0] AF_THR = (A+1)'(DEPTH - AF_SLACK);

    logic [A:0] r_wbin;
    logic [A:0] w_wbin_next;
    logic [A:0] w_wgray_next;
    logic [A:0] w_rbin;
    logic [A:0] w_level_next;
    logic [A:0] w_full_cmp;
    logic       w_accept;

    assign w_accept     = i_wr_en & ~o_wfull;
    assign o_wr_accept  = w_accept;
    assign o_waddr      = r_wbin[A-1:0];
    assign w_wbin_next  = r_wbin + {{A{1'b0}}, w_accept};
    assign w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);
    assign w_level_next = w_wbin_next - w_rbin;
    assign w_full_cmp   = {~i_rq2_rptr[A:A-1], i_rq2_rptr[A-2:0]};

    // Gray to binary: each bit is the XOR of itself and all higher bits
    always_comb begin
        w_rbin = '0;
        for (int i = 0; i <= A; i++) begin
            w_rbin[i] = ^(i_rq2_rptr >> i);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wbin         <= '0;
            o_wptr         <= '0;
            o_wfull        <= 1'b0;
            o_walmost_full <= 1'b0;
            o_wlevel       <= '0;
            o_overflow     <= 1'b0;
        end else begin
            r_wbin         <= w_wbin_next;
            o_wptr         <= w_wgray_next;
            o_wfull        <= (w_wgray_next == w_full_cmp);
            o_walmost_full <= (w_level_next >= AF_THR) |
                              (w_wgray_next == w_full_cmp);
            o_wlevel       <= w_level_next;
            o_overflow     <= o_overflow | (i_wr_en & o_wfull);
        end
    end
endmodule

// File: tb/tb_async_fifo_wptr_full.sv
// Directed bench for async_fifo_wptr_full (ADDR_WIDTH=4, AF_SLACK=2).
module tb_async_fifo_wptr_full;
    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [4:0] rq2;
    logic       acc;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic       waf;
    logic [4:0] wlevel;
    logic       ovf;

    int n_cmp = 0;
    int n_err = 0;

    async_fifo_wptr_full #(.ADDR_WIDTH(4), .AF_SLACK(2)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_wr_en        (wr_en),
        .i_rq2_rptr     (rq2),
        .o_wr_accept    (acc),
        .o_waddr        (waddr),
        .o_wptr         (wptr),
        .o_wfull        (wfull),
        .o_walmost_full (waf),
        .o_wlevel       (wlevel),
        .o_overflow     (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] h1, h2, prev, mbin;
        int         nacc;
        bit         wrap_seen;

        rst   = 1'b1;
        wr_en = 1'b1;
        rq2   = 5'd0;
        #1;
        tick();
        tick();
        chk("rst_wptr", wptr, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_full", wfull, 0);
        chk("rst_af", waf, 0);
        chk("rst_level", wlevel, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_acc_hi", acc, 1);
        wr_en = 1'b0;
        #1;
        chk("rst_acc_lo", acc, 0);
        rst = 1'b0;

        for (int i = 1; i <= 16; i++) begin
            wr_en = 1'b1;
            tick();
            chk("fill_level", wlevel, i);
            chk("fill_af", waf, (i >= 14) ? 1 : 0);
            chk("fill_full", wfull, (i == 16) ? 1 : 0);
        end
        chk("fill_wptr", wptr, 5'b11000);
        chk("fill_waddr", waddr, 0);

        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1;
            #1;
            chk("ovf_acc", acc, 0);
            tick();
            chk("ovf_wptr", wptr, 5'b11000);
            chk("ovf_waddr", waddr, 0);
            chk("ovf_flag", ovf, 1);
        end
        wr_en = 1'b0;
        tick();
        chk("ovf_sticky", ovf, 1);

        rq2 = 5'b00001;
        tick();
        chk("drain_full", wfull, 0);
        chk("drain_level", wlevel, 15);
        chk("drain_af", waf, 1);
        wr_en = 1'b1;
        tick();
        chk("refill_full", wfull, 1);
        chk("refill_wptr", wptr, 5'b11001);
        wr_en = 1'b0;

        mbin      = 5'd17;
        h1        = wptr;
        h2        = wptr;
        prev      = wptr;
        nacc      = 0;
        wrap_seen = 1'b0;
        for (int c = 0; c < 300 && nacc < 80; c++) begin
            wr_en = 1'b1;
            rq2   = h2;
            #1;
            if (acc) begin
                nacc++;
                mbin = mbin + 5'd1;
            end
            tick();
            chk("strm_wptr", wptr, mbin ^ (mbin >> 1));
            chk("strm_1bit", ($countones(prev ^ wptr) <= 1) ? 1 : 0, 1);
            chk("strm_full", wfull, 0);
            chk("strm_lvl3", (wlevel <= 5'd3) ? 1 : 0, 1);
            if (prev == 5'b10000 && wptr == 5'b00000) wrap_seen = 1'b1;
            prev = wptr;
            h2   = h1;
            h1   = wptr;
        end
        chk("strm_count", nacc, 80);
        chk("strm_wrap", wrap_seen, 1);

        rq2 = wptr;
        for (int i = 0; i < 9; i++) begin
            wr_en = 1'b1;
            tick();
        end
        chk("pre_rst_level", wlevel, 9);

        rst   = 1'b1;
        wr_en = 1'b1;
        rq2   = 5'd0;
        tick();
        rst   = 1'b0;
        wr_en = 1'b0;
        chk("mid_wptr", wptr, 0);
        chk("mid_waddr", waddr, 0);
        chk("mid_full", wfull, 0);
        chk("mid_af", waf, 0);
        chk("mid_level", wlevel, 0);
        chk("mid_ovf", ovf, 0);
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        chk("post_waddr", waddr, 1);
        chk("post_wptr", wptr, 5'b00001);
        chk("post_level", wlevel, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
